// File: rtl/ball_ctrl.sv
// ---------------------------------------------------------------------------
// ball_ctrl
//   Pong ball stage. This block sits after the two paddle instances. It moves a
//   square ball by one step on each animation step and bounces it off the
//   top/bottom walls and the paddles. When a paddle misses the ball, it pulses
//   the score output, advances a saturating score count and re-serves the ball
//   from the centre after a hold-off of SERVE_FRAMES steps.
//
// Ports
//   in_clock, in_reset     clock, synchronous active-high reset
//   in_ani_stb             one-cycle animation strobe per frame
//   in_animate             motion enable (low freezes everything but reset)
//   in_lbar_x2/y1/y2       left paddle right edge, top edge, bottom edge
//   in_rbar_x1/y1/y2       right paddle left edge, top edge, bottom edge
//   out_x1/x2, out_y1/y2   ball edges (centre -/+ H_SIZE), 12-bit unsigned
//   out_score_l/r          one-cycle pulse when the left/right player scores
//   out_count_l/r          score counts, saturate at 15
//   out_serving            high while the ball is held at the centre
//
// state | meaning
// ------+-------------------------------------------------------------
// SERVE | ball held at (IX,IY); serve counter advances on each step
// PLAY  | ball moves SPEED px per axis per step, bounces, detects misses
// ---------------------------------------------------------------------------
module ball_ctrl #(
    parameter int H_SIZE       = 8,
    parameter int IX           = 320,
    parameter int IY           = 240,
    parameter int SPEED        = 2,
    parameter int D_WIDTH      = 639,
    parameter int D_HEIGHT     = 470,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_ani_stb,
    input  logic        in_animate,
    input  logic [11:0] in_lbar_x2,
    input  logic [11:0] in_lbar_y1,
    input  logic [11:0] in_lbar_y2,
    input  logic [11:0] in_rbar_x1,
    input  logic [11:0] in_rbar_y1,
    input  logic [11:0] in_rbar_y2,
    output logic [11:0] out_x1,
    output logic [11:0] out_x2,
    output logic [11:0] out_y1,
    output logic [11:0] out_y2,
    output logic        out_score_l,
    output logic        out_score_r,
    output logic [3:0]  out_count_l,
    output logic [3:0]  out_count_r,
    output logic        out_serving
);

    localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [11:0]   HS12     = 12'(H_SIZE);
    localparam logic [11:0]   SP12     = 12'(SPEED);
    localparam logic [12:0]   HS13     = 13'(H_SIZE);
    localparam logic [12:0]   SP13     = 13'(SPEED);
    localparam logic [12:0]   DW13     = 13'(D_WIDTH);
    localparam logic [12:0]   DH13     = 13'(D_HEIGHT);
    localparam logic [11:0]   IX12     = 12'(IX);
    localparam logic [11:0]   IY12     = 12'(IY);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

    typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;

    state_t        state, state_n;
    logic [11:0]   x, y, x_n, y_n;
    logic          dx, dy, dx_n, dy_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          score_l, score_r, score_l_n, score_r_n;
    logic [3:0]    count_l, count_r, count_l_n, count_r_n;

    logic          step;
    logic [11:0]   x_lo, y_lo;
    logic [12:0]   x_hi, y_hi;
    logic          top_hit, bot_hit, l_hit, r_hit, l_miss, r_miss;

    assign step = in_animate & in_ani_stb;

    // Edges of the current position. The 13-bit forms keep the far-edge sums
    // free of overflow near the 12-bit limit.
    assign x_lo = x - HS12;
    assign y_lo = y - HS12;
    assign x_hi = {1'b0, x} + HS13;
    assign y_hi = {1'b0, y} + HS13;

    always_comb begin
        top_hit = ~dy & (y_lo <= SP12);
        bot_hit =  dy & ((y_hi + SP13) >= DH13);

        l_hit = ~dx
              & ({1'b0, x_lo} >= {1'b0, in_lbar_x2})
              & ({1'b0, x_lo} <= ({1'b0, in_lbar_x2} + SP13))
              & (y_hi >= {1'b0, in_lbar_y1})
              & (y_lo <= in_lbar_y2);

        // in_rbar_x1 - SPEED <= x_hi is rewritten as x_hi + SPEED >= in_rbar_x1,
        // so the comparison cannot underflow when the paddle is near x = 0.
        r_hit =  dx
              & ((x_hi + SP13) >= {1'b0, in_rbar_x1})
              & (x_hi <= {1'b0, in_rbar_x1})
              & (y_hi >= {1'b0, in_rbar_y1})
              & (y_lo <= in_rbar_y2);

        l_miss = ~dx & ~l_hit & (x_lo <= SP12);
        r_miss =  dx & ~r_hit & ((x_hi + SP13) >= DW13);
    end

    // State register and datapath registers
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state   <= SERVE;
            x       <= IX12;
            y       <= IY12;
            dx      <= 1'b1;
            dy      <= 1'b1;
            cnt     <= '0;
            score_l <= 1'b0;
            score_r <= 1'b0;
            count_l <= 4'd0;
            count_r <= 4'd0;
        end else begin
            state   <= state_n;
            x       <= x_n;
            y       <= y_n;
            dx      <= dx_n;
            dy      <= dy_n;
            cnt     <= cnt_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            count_l <= count_l_n;
            count_r <= count_r_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        if (step) begin
            case (state)
                SERVE:   if (cnt == CNT_LAST) state_n = PLAY;
                PLAY:    if (l_miss || r_miss) state_n = SERVE;
                default: state_n = SERVE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        x_n       = x;
        y_n       = y;
        dx_n      = dx;
        dy_n      = dy;
        cnt_n     = cnt;
        score_l_n = 1'b0;
        score_r_n = 1'b0;
        count_l_n = count_l;
        count_r_n = count_r;

        if (step) begin
            case (state)
                SERVE: begin
                    // The step that leaves SERVE does not move the ball.
                    if (cnt == CNT_LAST) cnt_n = '0;
                    else                 cnt_n = cnt + 1'b1;
                end
                PLAY: begin
                    if (l_miss) begin
                        // Serve toward the player who conceded. dy is kept.
                        x_n       = IX12;
                        y_n       = IY12;
                        dx_n      = 1'b0;
                        cnt_n     = '0;
                        score_r_n = 1'b1;
                        if (count_r != 4'd15) count_r_n = count_r + 4'd1;
                    end else if (r_miss) begin
                        x_n       = IX12;
                        y_n       = IY12;
                        dx_n      = 1'b1;
                        cnt_n     = '0;
                        score_l_n = 1'b1;
                        if (count_l != 4'd15) count_l_n = count_l + 4'd1;
                    end else begin
                        // Wall and paddle reflections are independent, so a
                        // corner hit flips both directions in the same step.
                        if (top_hit)      dy_n = 1'b1;
                        else if (bot_hit) dy_n = 1'b0;
                        if (l_hit)        dx_n = 1'b1;
                        else if (r_hit)   dx_n = 1'b0;
                        x_n = dx_n ? (x + SP12) : (x - SP12);
                        y_n = dy_n ? (y + SP12) : (y - SP12);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        out_x1      = x_lo;
        out_x2      = x_hi[11:0];
        out_y1      = y_lo;
        out_y2      = y_hi[11:0];
        out_score_l = score_l;
        out_score_r = score_r;
        out_count_l = count_l;
        out_count_r = count_r;
        out_serving = (state == SERVE);
    end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Pong ball stage sitting directly downstream of the two bar (paddle) instances.
- Consumes the paddle edge coordinates, moves a square ball one step per animation strobe and bounces it off the top/bottom walls and the paddles.
- Detects misses, produces score pulses and saturating score counts, and re-serves from centre.
- Ball edge outputs feed the pixel renderer in the same 12-bit coordinate format as the paddles.

Parameters:
- H_SIZE, 8, half ball side in pixels
- IX, 320, serve position x (ball centre)
- IY, 240, serve position y (ball centre)
- SPEED, 2, pixels moved per axis per animation step
- D_WIDTH, 639, display width
- D_HEIGHT, 470, display height
- SERVE_FRAMES, 60, animation steps the ball is held at centre before play

Ports:
- in_clock  input  1  base clock
- in_reset  input  1  synchronous active-high reset
- in_ani_stb  input  1  animation strobe, one in_clock cycle per frame
- in_animate  input  1  motion enable; low freezes all state except reset
- in_lbar_x2  input  12  left paddle right edge
- in_lbar_y1  input  12  left paddle top edge
- in_lbar_y2  input  12  left paddle bottom edge
- in_rbar_x1  input  12  right paddle left edge
- in_rbar_y1  input  12  right paddle top edge
- in_rbar_y2  input  12  right paddle bottom edge
- out_x1 / out_x2  output  12  ball left/right edge = x∓H_SIZE
- out_y1 / out_y2  output  12  ball top/bottom edge = y∓H_SIZE
- out_score_l  output  1  one-cycle pulse: left player scored
- out_score_r  output  1  one-cycle pulse: right player scored
- out_count_l / out_count_r  output  4  score counts, saturate at 15
- out_serving  output  1  high while in SERVE

Behaviour:
- Clock and reset: single clock in_clock; in_reset is synchronous and active-high.
- Reset values:
  - state=SERVE, x=IX, y=IY, dx=1 (right), dy=1 (down), serve counter=0.
  - Pulses=0, counts=0, out_serving=1.
  - Reset applies mid-play and wins over a coincident strobe.
- Step condition: step = in_animate && in_ani_stb. Nothing changes on cycles without step, except pulses clearing to 0 one cycle after assertion.
- Edge outputs are combinational from the x/y registers. All 12-bit unsigned; guards keep x,y ≥ H_SIZE, so there is no underflow.
- SERVE:
  - Ball held at (IX,IY); counter increments on each step.
  - Step with counter==SERVE_FRAMES-1 → PLAY, counter←0; ball does not move on that step.
- PLAY, per step, evaluated on the current position:
  - Top wall: dy=0 and y-H_SIZE ≤ SPEED → dy←1.
  - Bottom wall: dy=1 and y+H_SIZE+SPEED ≥ D_HEIGHT → dy←0.
  - Left hit: dx=0, in_lbar_x2 ≤ x-H_SIZE ≤ in_lbar_x2+SPEED, y+H_SIZE ≥ in_lbar_y1 and y-H_SIZE ≤ in_lbar_y2 → dx←1.
  - Right hit: dx=1, in_rbar_x1-SPEED ≤ x+H_SIZE ≤ in_rbar_x1, y+H_SIZE ≥ in_rbar_y1 and y-H_SIZE ≤ in_rbar_y2 → dx←0.
  - Left miss: dx=0, no left hit, x-H_SIZE ≤ SPEED.
    - out_score_r=1 for exactly one cycle, starting the cycle after the step.
    - count_r += 1, saturating at 15.
    - state←SERVE, x←IX, y←IY, dx←0 (serve toward the conceding side), dy unchanged, counter←0.
  - Right miss: mirror of left miss (x+H_SIZE+SPEED ≥ D_WIDTH) → out_score_l, count_l, dx←1.
  - Otherwise the position moves using the updated directions: x←x±SPEED, y←y±SPEED.
- Priority:
  - Paddle hit beats miss.
  - Wall and paddle reflections in the same step both apply (corner bounce).
  - A miss overrides any y update.
- Paddle inputs are sampled only on steps; they are assumed stable within a frame.

Test Plan:
- Serve timing: SERVE_FRAMES=4, reset, strobe every 10 cycles → out_serving drops on the 4th strobe; (x,y) stays (320,240) through it, then becomes (322,242) on the 5th.
- Freeze: in_animate=0 with strobes for 20 frames → outputs and serve counter unchanged; after raising in_animate, the serve completes after the remaining count.
- Bottom bounce: force PLAY with y=452, dy=1 → y+8+2=462 <470, so y=454; continuing to y=460 gives 470 ≥ 470, dy←0 and next y=458.
- Left paddle hit: x=20, dx=0, left paddle x2=10, y1=150, y2=330, ball y=240 → dx←1, next x=22; no score pulse.
- Left miss: paddle y1=0, y2=100, ball y=240 moving left until x-8 ≤ 2 → out_score_r high exactly 1 cycle, count_r=1, ball at (320,240), out_serving=1, dx=0.
- Saturation and reset: 16 right scores → count_r stays 15; assert in_reset mid-PLAY coincident with a strobe → all outputs return to reset values next cycle.
